// File: rtl/if_id_redirect_if.sv
// Fetch/decode boundary bundle: fetch outputs and hazard/redirect controls in,
// fetch steering and the IF/ID register contents out.
interface if_id_redirect_if;
  logic [31:0] if_pc;
  logic [31:0] if_pc8;
  logic [31:0] if_instr;
  logic        stall;
  logic        cmp_eq;
  logic [31:0] rs_val;
  logic        redirect_req;
  logic [31:0] redirect_pc;

  logic        ifu_enable;
  logic        ifu_npc_sel;
  logic [31:0] ifu_npc;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc8;
  logic        id_valid;
  logic        id_adel;
  logic        id_in_slot;
  logic        id_slot_err;

  modport master (
    output if_pc, if_pc8, if_instr, stall, cmp_eq, rs_val, redirect_req, redirect_pc,
    input  ifu_enable, ifu_npc_sel, ifu_npc, id_instr, id_pc, id_pc8,
           id_valid, id_adel, id_in_slot, id_slot_err
  );

  modport slave (
    input  if_pc, if_pc8, if_instr, stall, cmp_eq, rs_val, redirect_req, redirect_pc,
    output ifu_enable, ifu_npc_sel, ifu_npc, id_instr, id_pc, id_pc8,
           id_valid, id_adel, id_in_slot, id_slot_err
  );
endinterface

// File: rtl/if_id_redirect.sv
// IF/ID pipeline register with ID-stage branch/jump resolution, fetch steering,
// delay-slot tracking and fetch address error flagging.
module if_id_redirect #(
  parameter logic [31:0] PC_BASE   = 32'h0000_3000,
  parameter int unsigned ROM_WORDS = 1024
) (
  input logic              clk,
  input logic              Reset,
  if_id_redirect_if.slave  bus
);

  localparam logic [32:0] PC_END = 33'(PC_BASE) + 33'(4 * ROM_WORDS);

  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc8_q, id_pc8_d;
  logic        id_valid_q, id_valid_d;
  logic        id_adel_q, id_adel_d;
  logic        id_in_slot_q, id_in_slot_d;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic        is_beq, is_bne, is_j, is_jal, is_jr, is_jalr;
  logic        is_cti, taken;
  logic [31:0] pc_plus4, br_target, j_target, target;
  logic        fetch_bad;

  assign op    = id_instr_q[31:26];
  assign funct = id_instr_q[5:0];

  assign is_beq  = id_valid_q & (op == 6'b000100);
  assign is_bne  = id_valid_q & (op == 6'b000101);
  assign is_j    = id_valid_q & (op == 6'b000010);
  assign is_jal  = id_valid_q & (op == 6'b000011);
  assign is_jr   = id_valid_q & (op == 6'b000000) & (funct == 6'b001000);
  assign is_jalr = id_valid_q & (op == 6'b000000) & (funct == 6'b001001);
  assign is_cti  = is_beq | is_bne | is_j | is_jal | is_jr | is_jalr;

  assign taken = (is_beq & bus.cmp_eq) | (is_bne & ~bus.cmp_eq)
               | is_j | is_jal | is_jr | is_jalr;

  assign pc_plus4  = id_pc_q + 32'd4;
  assign br_target = pc_plus4 + {{14{id_instr_q[15]}}, id_instr_q[15:0], 2'b00};
  assign j_target  = {pc_plus4[31:28], id_instr_q[25:0], 2'b00};

  always_comb begin
    target = br_target;
    if (is_j | is_jal)        target = j_target;
    else if (is_jr | is_jalr) target = bus.rs_val;
  end

  // Redirect beats stall so an exception is never lost behind a hazard.
  always_comb begin
    bus.ifu_enable  = 1'b0;
    bus.ifu_npc_sel = 1'b0;
    bus.ifu_npc     = id_pc8_q;
    if (bus.redirect_req) begin
      bus.ifu_npc_sel = 1'b1;
      bus.ifu_npc     = bus.redirect_pc;
    end else if (bus.stall) begin
      bus.ifu_enable  = 1'b1;
    end else if (taken) begin
      bus.ifu_npc_sel = 1'b1;
      bus.ifu_npc     = target;
    end
  end

  assign fetch_bad = (bus.if_pc[1:0] != 2'b00) | (bus.if_pc < PC_BASE)
                   | ({1'b0, bus.if_pc} >= PC_END);

  always_comb begin
    id_instr_d   = id_instr_q;
    id_pc_d      = id_pc_q;
    id_pc8_d     = id_pc8_q;
    id_valid_d   = id_valid_q;
    id_adel_d    = id_adel_q;
    id_in_slot_d = id_in_slot_q;
    if (bus.redirect_req) begin
      id_instr_d   = 32'd0;
      id_valid_d   = 1'b0;
      id_adel_d    = 1'b0;
      id_in_slot_d = 1'b0;
    end else if (!bus.stall) begin
      id_instr_d   = fetch_bad ? 32'd0 : bus.if_instr;
      id_pc_d      = bus.if_pc;
      id_pc8_d     = bus.if_pc8;
      id_valid_d   = 1'b1;
      id_adel_d    = fetch_bad;
      id_in_slot_d = is_cti;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      id_instr_q   <= 32'd0;
      id_pc_q      <= PC_BASE;
      id_pc8_q     <= PC_BASE + 32'd8;
      id_valid_q   <= 1'b0;
      id_adel_q    <= 1'b0;
      id_in_slot_q <= 1'b0;
    end else begin
      id_instr_q   <= id_instr_d;
      id_pc_q      <= id_pc_d;
      id_pc8_q     <= id_pc8_d;
      id_valid_q   <= id_valid_d;
      id_adel_q    <= id_adel_d;
      id_in_slot_q <= id_in_slot_d;
    end
  end

  assign bus.id_instr    = id_instr_q;
  assign bus.id_pc       = id_pc_q;
  assign bus.id_pc8      = id_pc8_q;
  assign bus.id_valid    = id_valid_q;
  assign bus.id_adel     = id_adel_q;
  assign bus.id_in_slot  = id_in_slot_q;
  assign bus.id_slot_err = id_valid_q & id_in_slot_q & is_cti;

endmodule

// File: doc/if_id_redirect.md
Name: if_id_redirect

Overview:
- Consumer and controller for the fetch unit's interface; sits between the fetch stage and decode.
- Captures fetch outputs (PC, PC+8, instruction) into the IF/ID pipeline register, with stall and flush.
- Resolves branch and jump instructions in ID and drives the fetch unit's freeze input, next-PC select and next-PC value.
- Tracks delay-slot status and flags fetch address errors.

Parameters:
- PC_BASE, 32'h0000_3000, first instruction address and fetch reset vector.
- ROM_WORDS, 1024, number of words in instruction ROM; legal fetch range is PC_BASE to PC_BASE+4*ROM_WORDS-4.

Ports:
- clk  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- if_pc  in  32  current fetch PC.
- if_pc8  in  32  fetch PC+8 (link address).
- if_instr  in  32  fetched instruction.
- stall  in  1  hazard unit request to freeze IF and ID.
- cmp_eq  in  1  ID comparator result, forwarded rs == rt.
- rs_val  in  32  forwarded rs value, used by jr/jalr.
- redirect_req  in  1  single-cycle exception/eret redirect from a later stage.
- redirect_pc  in  32  redirect target.
- ifu_enable  out  1  freeze to fetch unit; 1 = hold PC, 0 = advance.
- ifu_npc_sel  out  1  1 = fetch loads ifu_npc, 0 = PC+4.
- ifu_npc  out  32  next-PC target.
- id_instr  out  32  IF/ID instruction.
- id_pc  out  32  IF/ID PC.
- id_pc8  out  32  IF/ID PC+8.
- id_valid  out  1  IF/ID holds a real instruction.
- id_adel  out  1  IF/ID instruction came from an illegal fetch address.
- id_in_slot  out  1  IF/ID instruction is a branch delay slot.
- id_slot_err  out  1  control-transfer instruction sits in a delay slot.

Behaviour:
- Reset values, next edge with Reset=1:
  - id_instr=0, id_pc=PC_BASE, id_pc8=PC_BASE+8.
  - id_valid=0, id_adel=0, id_in_slot=0.
  - Reset overrides every other input.
- Decode of id_instr (combinational, gated by id_valid):
  - beq: op 000100. bne: op 000101. j: op 000010. jal: op 000011.
  - jr: op 000000, funct 001000. jalr: op 000000, funct 001001.
- Targets, all mod 2^32:
  - Branch: id_pc + 4 + (sign_extend(imm16) << 2).
  - j/jal: {id_pc_plus4[31:28], instr[25:0], 2'b00}.
  - jr/jalr: rs_val.
- is_cti = any of the six instructions above.
- taken:
  - beq: cmp_eq.
  - bne: !cmp_eq.
  - j/jal/jr/jalr: always.
- Output priority (combinational, no added latency):
  1. redirect_req: ifu_enable=0, ifu_npc_sel=1, ifu_npc=redirect_pc.
  2. stall: ifu_enable=1, ifu_npc_sel=0.
  3. taken: ifu_enable=0, ifu_npc_sel=1, ifu_npc=target.
  4. Otherwise: ifu_enable=0, ifu_npc_sel=0, ifu_npc=id_pc8.
- IF/ID register, priority order:
  - Reset: load the reset values above.
  - redirect_req, even if stall is high: load bubble. Bubble is id_instr=0, id_valid=0, id_in_slot=0, id_adel=0; id_pc and id_pc8 hold.
  - stall: hold all fields.
  - Otherwise: load id_instr, id_pc, id_pc8 from the if_* inputs and set id_valid=1.
    - Illegal fetch address: if_pc[1:0]!=0, or if_pc < PC_BASE, or if_pc >= PC_BASE+4*ROM_WORDS. Then id_instr loads 0 and id_adel=1.
    - id_in_slot loads (id_valid & is_cti) of the outgoing ID instruction.
- Delay slot: the instruction in IF when a branch resolves is always executed; no flush for a taken branch.
- Stall with a branch in ID: the branch is held and re-resolved each cycle. The redirect is issued on the first non-stalled cycle using the cmp_eq and rs_val values present in that cycle.
- id_slot_err = id_valid & id_in_slot & is_cti. It is a flag only; no blocking.
- Reset mid-stall or mid-branch: pending state is discarded; the register is a plain reset-state bubble.

Test Plan:
- Reset, then fetch 0x3000/0x3004 with stall=0 and no CTI:
  - Cycle 1: id_valid=0, ifu_npc_sel=0.
  - Next edge: id_pc=0x3000 and id_valid=1.
- beq at 0x3008 with imm=0x0003 and cmp_eq=1:
  - In ID: ifu_npc_sel=1, ifu_npc=0x3018.
  - Next edge: ID holds the slot at 0x300C with id_in_slot=1.
  - With cmp_eq=0: ifu_npc_sel=0.
- jr in ID with rs_val=0x3100 and stall=1 for 2 cycles:
  - Stalled cycles: ifu_enable=1, IF/ID unchanged.
  - Third cycle: ifu_enable=0, ifu_npc=0x3100.
- redirect_req=1 with redirect_pc=0x4180, stall=1, and a j in ID:
  - Same cycle: ifu_enable=0, ifu_npc=0x4180.
  - Next edge: id_valid=0, id_instr=0.
- if_pc=0x4000 (out of range) and if_pc=0x3002 (misaligned):
  - Each gives id_adel=1, id_instr=0, id_valid=1.
- j in the delay slot of bne:
  - id_slot_err=1 while the j is in ID.
  - Both targets issue in order: bne target first, then j target.
